// File: rtl/amiga_daug_dram_ctrl.sv
// rtl/amiga_daug_dram_ctrl.sv - 68000-bus DRAM controller: banked RAS/CAS, muxed address, CBR refresh, write-protect latch
module amiga_daug_dram_ctrl #(
    parameter int ADDR_W      = 23,
    parameter int ROW_W       = 8,
    parameter int BANK_W      = 1,
    parameter int BASE        = 'h3F,
    parameter int REFRESH_DIV = 64,
    parameter int RAS_CYC     = 2,
    parameter int CAS_CYC     = 2,
    parameter int PRE_CYC     = 2,
    localparam int NBANKS     = 2 ** BANK_W
) (
    input  logic              CLK,
    input  logic              _RST,
    input  logic [ADDR_W:1]   A,
    input  logic              _AS,
    input  logic              _UDS,
    input  logic              _LDS,
    input  logic              _PRW,
    input  logic              WP_SET,
    output logic [ROW_W-1:0]  DRAM_A,
    output logic [NBANKS-1:0] _RAS,
    output logic              _CASU,
    output logic              _CASL,
    output logic              _WE,
    output logic              _DTACK,
    output logic              _DBUF_OE,
    output logic              DBUF_DIR,
    output logic              _WPRO
);
    localparam int TAG_W = ADDR_W - 2 * ROW_W - BANK_W;
    localparam int TMR_W = $clog2(RAS_CYC + CAS_CYC + PRE_CYC + 1);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic [2:0] {
        S_IDLE, S_ROW, S_COL, S_ACK, S_PRE, S_REF_CAS, S_REF_RAS
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic               ref_pend_q, ref_pend_d;
    logic               wp_q, wp_d;
    logic [ROW_W-1:0]   row_q, row_d, col_q, col_d;
    logic [BANK_W-1:0]  bank_q, bank_d;
    logic               uds_q, uds_d, lds_q, lds_d, prw_q, prw_d;
    logic               inh_q, inh_d;

    logic [TAG_W-1:0]   tag;
    logic               req, ref_tick;
    logic [NBANKS-1:0]  bank_ras;

    assign tag      = A[ADDR_W:2*ROW_W+BANK_W+1];
    assign req      = !_AS && (tag == TAG_W'(BASE)) && (!_UDS || !_LDS);
    assign ref_tick = (ref_cnt_q == '0);
    assign bank_ras = ~(NBANKS'(1) << bank_q);
    assign _WPRO    = ~wp_q;

    always_comb begin
        state_d    = state_q;
        tmr_d      = (tmr_q != '0) ? tmr_q - TMR_W'(1) : '0;
        ref_cnt_d  = ref_tick ? CNT_W'(REFRESH_DIV - 1) : ref_cnt_q - CNT_W'(1);
        // A tick landing while REF_CAS consumes the request still wins, so none is lost.
        ref_pend_d = ref_tick || (ref_pend_q && state_q != S_REF_CAS);
        wp_d       = wp_q || WP_SET;
        row_d      = row_q;
        col_d      = col_q;
        bank_d     = bank_q;
        uds_d      = uds_q;
        lds_d      = lds_q;
        prw_d      = prw_q;
        inh_d      = inh_q;

        DRAM_A     = '0;
        _RAS       = '1;
        _CASU      = 1'b1;
        _CASL      = 1'b1;
        _WE        = 1'b1;
        _DTACK     = 1'b1;
        _DBUF_OE   = 1'b1;
        DBUF_DIR   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ref_pend_q) begin
                    state_d = S_REF_CAS;
                end else if (req) begin
                    state_d = S_ROW;
                    tmr_d   = TMR_W'(RAS_CYC - 1);
                    col_d   = A[ROW_W:1];
                    row_d   = A[2*ROW_W:ROW_W+1];
                    bank_d  = A[2*ROW_W+BANK_W:2*ROW_W+1];
                    uds_d   = _UDS;
                    lds_d   = _LDS;
                    prw_d   = _PRW;
                    // Protected writes run full timing but never strobe CAS or WE.
                    inh_d   = wp_q && !_PRW;
                end
            end
            S_ROW: begin
                DRAM_A = row_q;
                _RAS   = bank_ras;
                if (tmr_q == '0) begin
                    state_d = S_COL;
                    tmr_d   = TMR_W'(CAS_CYC - 1);
                end
            end
            S_COL, S_ACK: begin
                DRAM_A   = col_q;
                _RAS     = bank_ras;
                _CASU    = uds_q || inh_q;
                _CASL    = lds_q || inh_q;
                _WE      = prw_q || inh_q;
                _DBUF_OE = 1'b0;
                DBUF_DIR = prw_q;
                _DTACK   = (state_q != S_ACK);
                if (state_q == S_COL && tmr_q == '0) begin
                    state_d = S_ACK;
                end else if (state_q == S_ACK && _AS) begin
                    state_d = S_PRE;
                    tmr_d   = TMR_W'(PRE_CYC - 1);
                end
            end
            S_PRE: begin
                if (tmr_q == '0) state_d = S_IDLE;
            end
            S_REF_CAS: begin
                _CASU   = 1'b0;
                _CASL   = 1'b0;
                state_d = S_REF_RAS;
                tmr_d   = TMR_W'(RAS_CYC + CAS_CYC - 1);
            end
            S_REF_RAS: begin
                _RAS  = '0;
                _CASU = 1'b0;
                _CASL = 1'b0;
                if (tmr_q == '0) begin
                    state_d = S_PRE;
                    tmr_d   = TMR_W'(PRE_CYC - 1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            ref_cnt_q  <= CNT_W'(REFRESH_DIV - 1);
            ref_pend_q <= 1'b0;
            wp_q       <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            bank_q     <= '0;
            uds_q      <= 1'b1;
            lds_q      <= 1'b1;
            prw_q      <= 1'b1;
            inh_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
            wp_q       <= wp_d;
            row_q      <= row_d;
            col_q      <= col_d;
            bank_q     <= bank_d;
            uds_q      <= uds_d;
            lds_q      <= lds_d;
            prw_q      <= prw_d;
            inh_q      <= inh_d;
        end
    end
endmodule
